ir_nec_decoder: RTL

Receive-side counterpart of the 38 kHz IR carrier generator. It samples the demodulated output of the IR receiver module (idle high, low during carrier bursts) and decodes NEC remote-control frames and repeat codes. It measures pulse widths in microseconds, validates the frame, and presents address and command bytes to the game control logic (snake direction and start/pause) as single-cycle strobes.

---
 rtl/ir_nec_decoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ir_nec_decoder.sv
// NEC IR remote decoder: measures mark/space widths in microseconds on the
// synchronized receiver output and emits address/command or repeat strobes.
module ir_nec_decoder #(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter bit          CHECK_ADDR_INV = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_in,
  output logic       data_valid,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       repeat_pulse,
  output logic       err
);

  localparam int unsigned DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  localparam logic [13:0] LEAD_MARK_MIN  = 14'd8000;
  localparam logic [13:0] LEAD_MARK_MAX  = 14'd10000;
  localparam logic [13:0] LEAD_DATA_MIN  = 14'd4000;
  localparam logic [13:0] LEAD_DATA_MAX  = 14'd5000;
  localparam logic [13:0] LEAD_RPT_MIN   = 14'd2000;
  localparam logic [13:0] LEAD_RPT_MAX   = 14'd2500;
  localparam logic [13:0] SHORT_MIN      = 14'd400;
  localparam logic [13:0] SHORT_MAX      = 14'd700;
  localparam logic [13:0] ONE_MIN        = 14'd1400;
  localparam logic [13:0] ONE_MAX        = 14'd1900;
  localparam logic [13:0] TIMEOUT_US     = 14'd12000;

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_STOP
  } state_t;

  state_t        state_q, state_d;
  logic          ir_s1, ir_s2, ir_prev;
  logic [PW-1:0] pre_q;
  logic [13:0]   width_q;
  logic [4:0]    idx_q, idx_d;
  logic [31:0]   shreg_q, shreg_d;
  logic          have_q;
  logic          dv_d, rpt_d, err_d;

  function automatic logic in_win(input logic [13:0] w, input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  logic fall, rise, edge_any, tick, timeout;
  logic lead_mark_ok, lead_data_ok, lead_rpt_ok, mark_ok, zero_ok, one_ok, bit_ok;
  logic frame_ok;

  assign fall     = ir_prev & ~ir_s2;
  assign rise     = ~ir_prev & ir_s2;
  assign edge_any = fall | rise;
  assign tick     = (pre_q == PRE_MAX);
  assign timeout  = (state_q != IDLE) && !edge_any && (width_q == TIMEOUT_US);

  assign lead_mark_ok = in_win(width_q, LEAD_MARK_MIN, LEAD_MARK_MAX);
  assign lead_data_ok = in_win(width_q, LEAD_DATA_MIN, LEAD_DATA_MAX);
  assign lead_rpt_ok  = in_win(width_q, LEAD_RPT_MIN, LEAD_RPT_MAX);
  assign mark_ok      = in_win(width_q, SHORT_MIN, SHORT_MAX);
  assign zero_ok      = mark_ok;
  assign one_ok       = in_win(width_q, ONE_MIN, ONE_MAX);
  assign bit_ok       = zero_ok | one_ok;

  // Shift register holds addr, addr_inv, cmd, cmd_inv from LSB upward.
  assign frame_ok = (shreg_q[31:24] == ~shreg_q[23:16]) &&
                    (!CHECK_ADDR_INV || (shreg_q[15:8] == ~shreg_q[7:0]));

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_s1        <= 1'b1;
      ir_s2        <= 1'b1;
      ir_prev      <= 1'b1;
      pre_q        <= '0;
      width_q      <= '0;
      state_q      <= IDLE;
      idx_q        <= '0;
      shreg_q      <= '0;
      have_q       <= 1'b0;
      data_valid   <= 1'b0;
      repeat_pulse <= 1'b0;
      err          <= 1'b0;
      addr         <= '0;
      cmd          <= '0;
    end else begin
      ir_s1   <= ir_in;
      ir_s2   <= ir_s1;
      ir_prev <= ir_s2;
      pre_q   <= (edge_any || tick) ? '0 : pre_q + 1'b1;
      if (edge_any)
        width_q <= '0;
      else if (tick && width_q != '1)
        width_q <= width_q + 14'd1;
      state_q      <= state_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      data_valid   <= dv_d;
      repeat_pulse <= rpt_d;
      err          <= err_d;
      if (dv_d) begin
        addr   <= shreg_q[7:0];
        cmd    <= shreg_q[23:16];
        have_q <= 1'b1;
      end
    end
  end

  // Failed widths drop to IDLE rather than restarting; the next leader resyncs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (timeout) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (fall) state_d = LEAD_MARK;
        LEAD_MARK:  if (rise) state_d = lead_mark_ok ? LEAD_SPACE : IDLE;
        LEAD_SPACE: if (fall) begin
          if (lead_data_ok) begin
            state_d = BIT_MARK;
            idx_d   = '0;
          end else if (lead_rpt_ok) begin
            state_d = RPT_STOP;
          end else begin
            state_d = IDLE;
          end
        end
        BIT_MARK:   if (rise) state_d = mark_ok ? BIT_SPACE : IDLE;
        BIT_SPACE:  if (fall) begin
          if (bit_ok) begin
            shreg_d = {one_ok, shreg_q[31:1]};
            if (idx_q == 5'd31) begin
              state_d = STOP_MARK;
            end else begin
              state_d = BIT_MARK;
              idx_d   = idx_q + 5'd1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        STOP_MARK, RPT_STOP: if (rise) state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    dv_d  = 1'b0;
    rpt_d = 1'b0;
    err_d = timeout;
    case (state_q)
      LEAD_MARK:  if (rise && !lead_mark_ok) err_d = 1'b1;
      LEAD_SPACE: if (fall && !lead_data_ok && !lead_rpt_ok) err_d = 1'b1;
      BIT_MARK:   if (rise && !mark_ok) err_d = 1'b1;
      BIT_SPACE:  if (fall && !bit_ok) err_d = 1'b1;
      STOP_MARK:  if (rise) begin
        if (mark_ok && frame_ok) dv_d = 1'b1;
        else err_d = 1'b1;
      end
      RPT_STOP:   if (rise) begin
        if (mark_ok && have_q) rpt_d = 1'b1;
        else err_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
